xalu_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage; owns the HI/LO register pair.
- Accepts mult/multu/div/divu/mthi/mtlo from the E-stage instruction.
- Models fixed multi-cycle latency and drives Busy/Start to the hazard/stall unit, which stalls any D-stage XALU instruction while Busy.
- HI/LO outputs feed the E-stage result mux for mfhi/mflo.

---
 rtl/xalu_muldiv.sv | 143 ++++++++++++++
 tb/tb_xalu_muldiv.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/xalu_muldiv.sv
// Multi-cycle multiply/divide unit for the EX stage. Owns the HI/LO pair,
// models a fixed per-operation latency and exposes Start/Busy to the stall unit.
module xalu_muldiv #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  XALUOp,
  input  logic        IntReq,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } op_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state, state_nx;
  logic [3:0]  count, count_nx;
  logic [31:0] hi_nx, lo_nx;
  logic [31:0] pend_hi, pend_lo, pend_hi_nx, pend_lo_nx;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] div_b;
  logic signed [31:0] quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;

  // Arithmetic datapath; a zero divisor is replaced by 1 so the divider never
  // produces X, and the result is discarded in that case anyway.
  always_comb begin
    div_b  = (B == '0) ? 32'd1 : B;
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    quot_s = $signed(A) / $signed(div_b);
    rem_s  = $signed(A) % $signed(div_b);
    quot_u = A / div_b;
    rem_u  = A % div_b;
  end

  // Handshake outputs seen by the hazard/stall unit.
  always_comb begin
    Start = (XALUOp inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) &&
            (state == IDLE) && !IntReq;
    Busy  = (state == RUN);
  end

  // Next-state, counter, pending-result and HI/LO update logic.
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    hi_nx      = HI;
    lo_nx      = LO;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nx = RUN;
          case (XALUOp)
            OP_MULT: begin
              count_nx   = MULT_LOAD;
              pend_hi_nx = prod_s[63:32];
              pend_lo_nx = prod_s[31:0];
            end
            OP_MULTU: begin
              count_nx   = MULT_LOAD;
              pend_hi_nx = prod_u[63:32];
              pend_lo_nx = prod_u[31:0];
            end
            OP_DIV: begin
              count_nx   = DIV_LOAD;
              // Divide by zero: pending mirrors current HI/LO so commit is a no-op.
              pend_hi_nx = (B == '0) ? HI : rem_s;
              pend_lo_nx = (B == '0) ? LO : quot_s;
            end
            default: begin
              count_nx   = DIV_LOAD;
              pend_hi_nx = (B == '0) ? HI : rem_u;
              pend_lo_nx = (B == '0) ? LO : quot_u;
            end
          endcase
        end else if (!IntReq) begin
          if (XALUOp == OP_MTHI) begin
            hi_nx = A;
          end else if (XALUOp == OP_MTLO) begin
            lo_nx = A;
          end
        end
      end
      RUN: begin
        if (count == 4'd1) begin
          hi_nx    = pend_hi;
          lo_nx    = pend_lo;
          count_nx = '0;
          state_nx = IDLE;
        end else begin
          count_nx = count - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register with synchronous reset that also drops any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      HI      <= '0;
      LO      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      HI      <= hi_nx;
      LO      <= lo_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
    end
  end

endmodule

// File: tb/tb_xalu_muldiv.sv
// Scoreboard bench for xalu_muldiv: stimulus pushes expected HI/LO and Busy
// length per operation; a monitor checks them whenever Busy falls.
module tb_xalu_muldiv;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        int_req;
  logic        start, busy;
  logic [31:0] hi, lo;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned len;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  xalu_muldiv #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(a), .B(b), .XALUOp(op), .IntReq(int_req),
    .Start(start), .Busy(busy), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle, check Start at the negedge, then clear it.
  task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic ir, input logic exp_start, input string name);
    op = o; a = av; b = bv; int_req = ir;
    @(negedge clk);
    chk({name, "_start"}, {31'd0, start}, {31'd0, exp_start});
    step();
    op = 4'd0; int_req = 1'b0;
  endtask

  task automatic push(input string name, input logic [31:0] h, input logic [31:0] l,
                      input int unsigned len);
    exp_t e;
    e.name = name; e.hi = h; e.lo = l; e.len = len;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int i = 0;
    while (sb.size() != 0 && i < 60) begin
      step();
      i++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=pending required=committed", name);
      sb.delete();
    end
  endtask

  // Monitor: count Busy cycles; on the falling edge of Busy compare HI/LO/length.
  initial begin
    int unsigned blen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        blen++;
      end else if (blen > 0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit actual=hi %h lo %h required=none", hi, lo);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_hi"}, hi, e.hi);
          chk({e.name, "_lo"}, lo, e.lo);
          chk({e.name, "_busy_len"}, blen, e.len);
        end
        blen = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; a = '0; b = '0; op = 4'd0; int_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    step();

    // mult -1 * 2 = -2
    push("mult", 32'hFFFFFFFF, 32'hFFFFFFFE, MC);
    issue(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1, "mult");
    @(negedge clk);
    chk("mult_start_drop", {31'd0, start}, 32'd0);
    chk("mult_hi_old_in_run", hi, 32'h0);
    wait_done("mult");

    // multu 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    push("multu", 32'h00000001, 32'hFFFFFFFE, MC);
    issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b1, "multu");
    wait_done("multu");

    // div -7 / 2 = -3 rem -1
    push("div", 32'hFFFFFFFF, 32'hFFFFFFFD, DC);
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1, "div");
    wait_done("div");

    // mthi / mtlo take effect the next cycle without Busy
    issue(4'd5, 32'h00001234, 32'd0, 1'b0, 1'b0, "mthi");
    @(negedge clk);
    chk("mthi_hi", hi, 32'h00001234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    step();
    issue(4'd6, 32'h00005678, 32'd0, 1'b0, 1'b0, "mtlo");
    @(negedge clk);
    chk("mtlo_lo", lo, 32'h00005678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    step();

    // divu by zero keeps HI/LO
    push("divu0", 32'h00001234, 32'h00005678, DC);
    issue(4'd4, 32'd7, 32'd0, 1'b0, 1'b1, "divu0");
    wait_done("divu0");

    // mult suppressed by IntReq
    issue(4'd1, 32'd3, 32'd4, 1'b1, 1'b0, "mult_int");
    @(negedge clk);
    chk("mult_int_busy", {31'd0, busy}, 32'd0);
    chk("mult_int_hi", hi, 32'h00001234);
    chk("mult_int_lo", lo, 32'h00005678);
    step();

    // IntReq pulse during RUN does not disturb the operation
    push("mult_irq_run", 32'h0, 32'd12, MC);
    issue(4'd1, 32'd3, 32'd4, 1'b0, 1'b1, "mult_irq_run");
    step();
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    wait_done("mult_irq_run");

    // reset on Busy cycle 3 aborts; no later commit
    push("mult_rst", 32'h0, 32'h0, 3);
    issue(4'd1, 32'h00010000, 32'h00010000, 1'b0, 1'b1, "mult_rst");
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_done("mult_rst");
    repeat (8) step();
    @(negedge clk);
    chk("post_rst_hi", hi, 32'h0);
    chk("post_rst_lo", lo, 32'h0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    step();

    // mtlo issued during RUN is ignored
    push("mult_mtlo", 32'h00000001, 32'h00030000, MC);
    issue(4'd1, 32'h00010000, 32'h00010003, 1'b0, 1'b1, "mult_mtlo");
    issue(4'd6, 32'h0000DEAD, 32'd0, 1'b0, 1'b0, "mtlo_in_run");
    @(negedge clk);
    chk("mtlo_in_run_lo_old", lo, 32'h0);
    wait_done("mult_mtlo");
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
